ex10_payment_check: RTL and testbench

- Payment-comparison block of the digital vending machine.
- Decides combinationally whether the inserted credit (paid) covers the selected item price (is_sufficient).
- Also provides a registered, strobed result with change/shortfall amounts for the downstream dispense/refund controller.
- Sits between the coin-accumulator and the vending FSM.

---
 rtl/vend_pkg.sv | 11 +
 rtl/vend_cmp_core.sv | 24 ++
 rtl/ex10_payment_check.sv | 55 +++++
 tb/tb_ex10_payment_check.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared vending-machine widths and credit/price types used by the
// coin accumulator, the payment check and the vending FSM.
package vend_pkg;

    localparam int PAID_W  = 5;
    localparam int PRICE_W = 4;

    typedef logic [PAID_W-1:0]  credit_t;
    typedef logic [PRICE_W-1:0] price_t;

endpackage

// File: rtl/vend_cmp_core.sv
// Combinational credit-versus-price comparator producing the
// sufficiency flag and both difference amounts.
module vend_cmp_core
    import vend_pkg::*;
#(
    parameter int PAID_W  = vend_pkg::PAID_W,
    parameter int PRICE_W = vend_pkg::PRICE_W
) (
    input  logic [PAID_W-1:0]  paid,
    input  logic [PRICE_W-1:0] price,
    output logic               ge,
    output logic [PAID_W-1:0]  diff_change,
    output logic [PRICE_W-1:0] diff_short
);

    logic [PAID_W-1:0] price_ext;

    assign price_ext   = PAID_W'(price);
    assign ge          = (paid >= price_ext);
    assign diff_change = paid - price_ext;
    // Only meaningful when price > paid, which bounds paid below 2**PRICE_W.
    assign diff_short  = price - paid[PRICE_W-1:0];

endmodule

// File: rtl/ex10_payment_check.sv
// Payment check: combinational sufficiency flag plus a strobed,
// registered result carrying change or shortfall for the dispense logic.
module ex10_payment_check
    import vend_pkg::*;
#(
    parameter int PAID_W  = vend_pkg::PAID_W,
    parameter int PRICE_W = vend_pkg::PRICE_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PAID_W-1:0]  paid,
    input  logic [PRICE_W-1:0] price,
    input  logic               cmp_req,
    output logic               is_sufficient,
    output logic               res_valid,
    output logic               res_ok,
    output logic [PAID_W-1:0]  change,
    output logic [PRICE_W-1:0] shortfall
);

    logic               ge;
    logic [PAID_W-1:0]  diff_change;
    logic [PRICE_W-1:0] diff_short;

    vend_cmp_core #(
        .PAID_W  (PAID_W),
        .PRICE_W (PRICE_W)
    ) u_cmp_core (
        .paid        (paid),
        .price       (price),
        .ge          (ge),
        .diff_change (diff_change),
        .diff_short  (diff_short)
    );

    assign is_sufficient = ge;

    // Result registers hold between strobes; only res_valid is a pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_ok    <= 1'b0;
            change    <= '0;
            shortfall <= '0;
        end else begin
            res_valid <= cmp_req;
            if (cmp_req) begin
                res_ok    <= ge;
                change    <= ge ? diff_change : '0;
                shortfall <= ge ? '0 : diff_short;
            end
        end
    end

endmodule

// File: tb/tb_ex10_payment_check.sv
// Self-checking bench for ex10_payment_check with a behavioural
// integer-arithmetic reference model of the registered result.
module tb_ex10_payment_check;
    import vend_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    credit_t       paid;
    price_t        price;
    logic          cmp_req;
    logic          is_sufficient;
    logic          res_valid;
    logic          res_ok;
    credit_t       change;
    price_t        shortfall;

    int checks = 0;
    int errors = 0;

    logic    exp_valid;
    logic    exp_ok;
    credit_t exp_change;
    price_t  exp_short;

    ex10_payment_check dut (
        .clk           (clk),
        .rst           (rst),
        .paid          (paid),
        .price         (price),
        .cmp_req       (cmp_req),
        .is_sufficient (is_sufficient),
        .res_valid     (res_valid),
        .res_ok        (res_ok),
        .change        (change),
        .shortfall     (shortfall)
    );

    always #5 clk = ~clk;

    // Reference model: result of one clock edge from plain arithmetic.
    task automatic step();
        int p;
        int q;
        p = int'(paid);
        q = int'(price);
        if (rst) begin
            exp_valid  = 1'b0;
            exp_ok     = 1'b0;
            exp_change = '0;
            exp_short  = '0;
        end else begin
            exp_valid = cmp_req;
            if (cmp_req) begin
                exp_ok     = (p >= q);
                exp_change = (p >= q) ? credit_t'(p - q) : '0;
                exp_short  = (p >= q) ? '0 : price_t'(q - p);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; cmp_req = 1'b1; paid = 5'd20; price = 4'd3;
        step();
        step();
        checks++;
        if ({res_valid, res_ok, change, shortfall} !== 11'h0) begin
            errors++;
            $display("FAIL reset_regs: got v=%0b ok=%0b ch=%0d sh=%0d, want all 0",
                     res_valid, res_ok, change, shortfall);
        end
        checks++;
        if (is_sufficient !== 1'b1) begin
            errors++;
            $display("FAIL reset_comb: got is_sufficient=%0b want 1", is_sufficient);
        end
        rst = 1'b0; cmp_req = 1'b0;
        step();
    endtask

    task automatic test_comb();
        logic [8:0] vec [7] = '{9'h1EA, 9'h0AA, 9'h14A, 9'h000, 9'h00F, 9'h3EF, 9'h1E0};
        logic exp;
        logic [8:0] v;
        for (int i = 0; i < 7; i++) begin
            v = vec[i];
            paid = v[8:4]; price = v[3:0];
            #1;
            exp = (int'(paid) >= int'(price));
            checks++;
            if (is_sufficient !== exp) begin
                errors++;
                $display("FAIL comb_vec%0d: paid=%0d price=%0d got %0b want %0b",
                         i, paid, price, is_sufficient, exp);
            end
        end
        for (int i = 0; i < 60; i++) begin
            paid = credit_t'($urandom); price = price_t'($urandom);
            #1;
            exp = (int'(paid) >= int'(price));
            checks++;
            if (is_sufficient !== exp) begin
                errors++;
                $display("FAIL comb_rand: paid=%0d price=%0d got %0b want %0b",
                         paid, price, is_sufficient, exp);
            end
        end
    endtask

    task automatic test_capture();
        int pv [3] = '{15, 5, 31};
        int qv [3] = '{10, 10, 0};
        for (int i = 0; i < 3; i++) begin
            paid = credit_t'(pv[i]); price = price_t'(qv[i]); cmp_req = 1'b1;
            step();
            checks++;
            if ({res_valid, res_ok, change, shortfall} !== {exp_valid, exp_ok, exp_change, exp_short}) begin
                errors++;
                $display("FAIL capture%0d: got v=%0b ok=%0b ch=%0d sh=%0d want v=%0b ok=%0b ch=%0d sh=%0d",
                         i, res_valid, res_ok, change, shortfall, exp_valid, exp_ok, exp_change, exp_short);
            end
            cmp_req = 1'b0; paid = 5'd1; price = 4'd9;
            step();
            checks++;
            if ({res_valid, res_ok, change, shortfall} !== {exp_valid, exp_ok, exp_change, exp_short}) begin
                errors++;
                $display("FAIL hold%0d: got v=%0b ok=%0b ch=%0d sh=%0d want v=%0b ok=%0b ch=%0d sh=%0d",
                         i, res_valid, res_ok, change, shortfall, exp_valid, exp_ok, exp_change, exp_short);
            end
        end
        // Fixed expectations for the first sufficient case independent of the model.
        paid = 5'd15; price = 4'd10; cmp_req = 1'b1;
        step();
        cmp_req = 1'b0;
        checks++;
        if ({res_valid, res_ok, change, shortfall} !== {1'b1, 1'b1, 5'd5, 4'd0}) begin
            errors++;
            $display("FAIL capture_fixed: got v=%0b ok=%0b ch=%0d sh=%0d want 1 1 5 0",
                     res_valid, res_ok, change, shortfall);
        end
        step();
    endtask

    task automatic test_reset_mid();
        paid = 5'd15; price = 4'd10; cmp_req = 1'b1;
        step();
        rst = 1'b1;
        step();
        checks++;
        if ({res_valid, res_ok, change, shortfall} !== 11'h0) begin
            errors++;
            $display("FAIL reset_mid: got v=%0b ok=%0b ch=%0d sh=%0d want all 0",
                     res_valid, res_ok, change, shortfall);
        end
        paid = 5'd3; #1;
        checks++;
        if (is_sufficient !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_comb: got %0b want 0", is_sufficient);
        end
        rst = 1'b0; cmp_req = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        logic ok_seq [3] = '{1'b0, 1'b1, 1'b1};
        price = 4'd9; cmp_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            paid = credit_t'(8 + i);
            step();
            checks++;
            if (res_valid !== 1'b1 || res_ok !== ok_seq[i] ||
                {res_ok, change, shortfall} !== {exp_ok, exp_change, exp_short}) begin
                errors++;
                $display("FAIL b2b%0d: got v=%0b ok=%0b ch=%0d sh=%0d want v=1 ok=%0b ch=%0d sh=%0d",
                         i, res_valid, res_ok, change, shortfall, ok_seq[i], exp_change, exp_short);
            end
        end
        cmp_req = 1'b0;
        step();
        checks++;
        if ({res_valid, res_ok, change, shortfall} !== {1'b0, 1'b1, 5'd1, 4'd0}) begin
            errors++;
            $display("FAIL b2b_end: got v=%0b ok=%0b ch=%0d sh=%0d want 0 1 1 0",
                     res_valid, res_ok, change, shortfall);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst     = ($urandom_range(0, 19) == 0);
            cmp_req = $urandom_range(0, 1) == 1;
            paid    = credit_t'($urandom);
            price   = price_t'($urandom);
            step();
            checks++;
            if ({res_valid, res_ok, change, shortfall} !== {exp_valid, exp_ok, exp_change, exp_short}) begin
                errors++;
                $display("FAIL random%0d: got v=%0b ok=%0b ch=%0d sh=%0d want v=%0b ok=%0b ch=%0d sh=%0d",
                         i, res_valid, res_ok, change, shortfall, exp_valid, exp_ok, exp_change, exp_short);
            end
        end
        rst = 1'b0; cmp_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cmp_req = 1'b0; paid = '0; price = '0;
        exp_valid = 1'b0; exp_ok = 1'b0; exp_change = '0; exp_short = '0;
        test_reset();
        test_comb();
        test_capture();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
